// File: rtl/bram_ddr3_mover.sv
// ============================================================================
// Module   : bram_ddr3_mover
// Brief    : Copies word blocks between a local BRAM and a DDR3 app port.
//            Optional stall watchdog: BRAM_DDR3_MOVER_TIMEOUT_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_ddr3_mover #(
    parameter int MEM_DEPTH  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_INC   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start_wr,
    input  logic                  i_start_rd,
    input  logic [27:0]           i_ddr_addr,
    input  logic [MEM_DEPTH:0]    i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_bram_we,
    output logic [MEM_DEPTH-1:0]  o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout,
    output logic                  o_app_en,
    output logic [2:0]            o_app_cmd,
    output logic [27:0]           o_app_addr,
    input  logic                  i_app_rdy,
    output logic                  o_app_wdf_wren,
    output logic                  o_app_wdf_end,
    output logic [DATA_WIDTH-1:0] o_app_wdf_data,
    input  logic                  i_app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0] i_app_rd_data,
    input  logic                  i_app_rd_data_valid
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_FETCH = 3'd1;
    localparam logic [2:0] ST_WR_LATCH = 3'd2;
    localparam logic [2:0] ST_WR_XFER  = 3'd3;
    localparam logic [2:0] ST_RD_XFER  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam logic [MEM_DEPTH:0]   CNT_ONE  = (MEM_DEPTH+1)'(1);
    localparam logic [MEM_DEPTH:0]   CNT_MAX  = {1'b1, {MEM_DEPTH{1'b0}}};
    localparam logic [MEM_DEPTH-1:0] PTR_ONE  = MEM_DEPTH'(1);
    localparam logic [27:0]          DDR_STEP = 28'(ADDR_INC);

    logic [2:0]            state_q, state_d;
    logic [MEM_DEPTH:0]    count_q, count_d;
    logic [MEM_DEPTH:0]    issued_q, issued_d;
    logic [MEM_DEPTH:0]    received_q, received_d;
    logic [27:0]           ddr_ptr_q, ddr_ptr_d;
    logic [MEM_DEPTH-1:0]  bram_ptr_q, bram_ptr_d;
    logic                  cmd_acc_q, cmd_acc_d;
    logic                  dat_acc_q, dat_acc_d;
    logic [DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;

    logic                  cmd_hs;
    logic                  dat_hs;
    logic                  stall_fire;
    logic [MEM_DEPTH:0]    issued_inc;
    logic [MEM_DEPTH:0]    received_inc;

    assign cmd_hs         = o_app_en & i_app_rdy;
    assign dat_hs         = o_app_wdf_wren & i_app_wdf_rdy;
    assign issued_inc     = issued_q + CNT_ONE;
    assign received_inc   = received_q + CNT_ONE;
    assign o_app_wdf_end  = o_app_wdf_wren;
    assign o_app_wdf_data = wdf_data_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            ddr_ptr_q  <= '0;
            bram_ptr_q <= '0;
            cmd_acc_q  <= 1'b0;
            dat_acc_q  <= 1'b0;
            wdf_data_q <= '0;
        end else begin
            count_q    <= count_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            ddr_ptr_q  <= ddr_ptr_d;
            bram_ptr_q <= bram_ptr_d;
            cmd_acc_q  <= cmd_acc_d;
            dat_acc_q  <= dat_acc_d;
            wdf_data_q <= wdf_data_d;
        end
    end

    // Next state and datapath
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        issued_d   = issued_q;
        received_d = received_q;
        ddr_ptr_d  = ddr_ptr_q;
        bram_ptr_d = bram_ptr_q;
        cmd_acc_d  = cmd_acc_q;
        dat_acc_d  = dat_acc_q;
        wdf_data_d = wdf_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start_wr || i_start_rd) begin
                    count_d    = (i_count > CNT_MAX) ? CNT_MAX : i_count;
                    ddr_ptr_d  = i_ddr_addr;
                    bram_ptr_d = '0;
                    issued_d   = '0;
                    received_d = '0;
                    cmd_acc_d  = 1'b0;
                    dat_acc_d  = 1'b0;
                    if (i_count == '0)   state_d = ST_DONE;
                    else if (i_start_wr) state_d = ST_WR_FETCH;
                    else                 state_d = ST_RD_XFER;
                end
            end
            ST_WR_FETCH: state_d = ST_WR_LATCH;
            ST_WR_LATCH: begin
                wdf_data_d = i_bram_dout;
                state_d    = ST_WR_XFER;
            end
            ST_WR_XFER: begin
                // Command and data channels complete independently; advance once both have.
                if ((cmd_acc_q || cmd_hs) && (dat_acc_q || dat_hs)) begin
                    cmd_acc_d  = 1'b0;
                    dat_acc_d  = 1'b0;
                    bram_ptr_d = bram_ptr_q + PTR_ONE;
                    ddr_ptr_d  = ddr_ptr_q + DDR_STEP;
                    issued_d   = issued_inc;
                    state_d    = (issued_inc == count_q) ? ST_DONE : ST_WR_FETCH;
                end else begin
                    cmd_acc_d = cmd_acc_q | cmd_hs;
                    dat_acc_d = dat_acc_q | dat_hs;
                end
            end
            ST_RD_XFER: begin
                if (cmd_hs) begin
                    issued_d  = issued_inc;
                    ddr_ptr_d = ddr_ptr_q + DDR_STEP;
                end
                if (i_app_rd_data_valid) begin
                    bram_ptr_d = bram_ptr_q + PTR_ONE;
                    received_d = received_inc;
                    if (received_inc == count_q) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (stall_fire) begin
            state_d   = ST_DONE;
            cmd_acc_d = 1'b0;
            dat_acc_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        o_busy         = (state_q != ST_IDLE);
        o_done         = 1'b0;
        o_bram_we      = 1'b0;
        o_bram_addr    = '0;
        o_bram_din     = '0;
        o_app_en       = 1'b0;
        o_app_cmd      = 3'b000;
        o_app_addr     = '0;
        o_app_wdf_wren = 1'b0;
        case (state_q)
            ST_WR_FETCH: o_bram_addr = bram_ptr_q;
            ST_WR_XFER: begin
                o_app_en       = ~cmd_acc_q;
                o_app_addr     = ddr_ptr_q;
                o_app_wdf_wren = ~dat_acc_q;
            end
            ST_RD_XFER: begin
                o_app_en   = (issued_q != count_q);
                o_app_cmd  = 3'b001;
                o_app_addr = ddr_ptr_q;
                if (i_app_rd_data_valid) begin
                    o_bram_we   = 1'b1;
                    o_bram_addr = bram_ptr_q;
                    o_bram_din  = i_app_rd_data;
                end
            end
            ST_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

`ifdef BRAM_DDR3_MOVER_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        error_q, error_d;

    always_comb begin
        stall_d    = stall_q;
        error_d    = error_q;
        stall_fire = 1'b0;
        if (state_q == ST_IDLE || cmd_hs || dat_hs || i_app_rd_data_valid) begin
            stall_d = '0;
        end else if (stall_q == 16'hFFFF) begin
            stall_fire = 1'b1;
            stall_d    = '0;
            error_d    = 1'b1;
        end else begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            error_q <= error_d;
        end
    end

    assign o_error = error_q;
`else
    assign stall_fire = 1'b0;
    assign o_error    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_ddr3_mover.sv
// ============================================================================
// Module   : tb_bram_ddr3_mover
// Brief    : Directed vector bench for bram_ddr3_mover with BRAM/DDR3 models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bram_ddr3_mover;
    localparam int MD   = 10;
    localparam int DW   = 32;
    localparam int STEP = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start_wr, i_start_rd;
    logic [27:0]   i_ddr_addr;
    logic [MD:0]   i_count;
    logic          o_busy, o_done, o_error, o_bram_we;
    logic [MD-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_din, i_bram_dout;
    logic          o_app_en;
    logic [2:0]    o_app_cmd;
    logic [27:0]   o_app_addr;
    logic          i_app_rdy, o_app_wdf_wren, o_app_wdf_end, i_app_wdf_rdy;
    logic [DW-1:0] o_app_wdf_data, i_app_rd_data;
    logic          i_app_rd_data_valid;

    always #5 clk = ~clk;

    bram_ddr3_mover #(.MEM_DEPTH(MD), .DATA_WIDTH(DW), .ADDR_INC(STEP)) dut (
        .clk(clk), .rst(rst),
        .i_start_wr(i_start_wr), .i_start_rd(i_start_rd),
        .i_ddr_addr(i_ddr_addr), .i_count(i_count),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr),
        .o_bram_din(o_bram_din), .i_bram_dout(i_bram_dout),
        .o_app_en(o_app_en), .o_app_cmd(o_app_cmd), .o_app_addr(o_app_addr),
        .i_app_rdy(i_app_rdy), .o_app_wdf_wren(o_app_wdf_wren),
        .o_app_wdf_end(o_app_wdf_end), .o_app_wdf_data(o_app_wdf_data),
        .i_app_wdf_rdy(i_app_wdf_rdy), .i_app_rd_data(i_app_rd_data),
        .i_app_rd_data_valid(i_app_rd_data_valid)
    );

    // Source BRAM feeds writes, destination BRAM collects reads.
    logic [DW-1:0] src_mem [0:(1<<MD)-1];
    logic [DW-1:0] dst_mem [0:(1<<MD)-1];
    always @(posedge clk) begin
        if (o_bram_we) dst_mem[o_bram_addr] <= o_bram_din;
        i_bram_dout <= src_mem[o_bram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rd_val(input logic [27:0] a);
        return {4'hD, a};
    endfunction

    typedef struct { int due; logic [DW-1:0] data; } ret_t;
    ret_t          ret_q[$];
    logic [27:0]   cmd_addr_log[$];
    logic [2:0]    cmd_code_log[$];
    logic [DW-1:0] wdata_log[$];
    logic [MD-1:0] we_addr_log[$];
    int en_cycles = 0, done_cnt = 0, done_cyc = 0, end_bad = 0;
    int rd_lat = 1, rdy_hold = 0, st_cyc = 0;

    // DDR3 responder and monitor: drive on negedge, sample 1 time unit later.
    initial begin
        i_app_rdy = 1'b1; i_app_wdf_rdy = 1'b1;
        i_app_rd_data_valid = 1'b0; i_app_rd_data = '0;
        forever begin
            @(negedge clk);
            i_app_rdy = (rdy_hold == 0);
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                i_app_rd_data_valid = 1'b1;
                i_app_rd_data = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                i_app_rd_data_valid = 1'b0;
                i_app_rd_data = '0;
            end
            #1;
            if (o_app_en) begin
                en_cycles++;
                if (rdy_hold > 0) rdy_hold--;
            end
            if (o_app_en && i_app_rdy) begin
                cmd_addr_log.push_back(o_app_addr);
                cmd_code_log.push_back(o_app_cmd);
                if (o_app_cmd == 3'b001) ret_q.push_back('{cyc + rd_lat, rd_val(o_app_addr)});
            end
            if (o_app_wdf_wren && i_app_wdf_rdy) wdata_log.push_back(o_app_wdf_data);
            if (o_app_wdf_end !== o_app_wdf_wren) end_bad++;
            if (o_bram_we) we_addr_log.push_back(o_bram_addr);
            if (o_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        ret_q.delete(); cmd_addr_log.delete(); cmd_code_log.delete();
        wdata_log.delete(); we_addr_log.delete();
        en_cycles = 0; done_cnt = 0; done_cyc = 0; end_bad = 0;
    endtask

    task automatic start(input bit wr, input bit rd, input logic [27:0] a, input logic [MD:0] n);
        @(negedge clk);
        i_start_wr = wr; i_start_rd = rd; i_ddr_addr = a; i_count = n; st_cyc = cyc;
        @(negedge clk);
        i_start_wr = 1'b0; i_start_rd = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while (done_cnt == 0 && t < bound) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        #2;
    endtask

    typedef struct {
        bit          wr;
        logic [27:0] addr;
        logic [MD:0] count;
        int          lat;
        int          stall;
        int          exp_words;
        int          exp_en;
        logic [27:0] exp_last;
    } vec_t;

    task automatic run_vec(input string nm, input vec_t v);
        int bad = 0;
        logic [27:0] ea;
        clear_logs();
        rd_lat = v.lat; rdy_hold = v.stall;
        @(negedge clk);
        start(v.wr, !v.wr, v.addr, v.count);
        wait_done(5000);
        check({nm, " done pulses"}, done_cnt, 1);
        check({nm, " cmds"}, cmd_addr_log.size(), v.exp_words);
        check({nm, " app_en cycles"}, en_cycles, v.exp_en);
        check({nm, " wdf beats"}, wdata_log.size(), v.wr ? v.exp_words : 0);
        check({nm, " bram writes"}, we_addr_log.size(), v.wr ? 0 : v.exp_words);
        for (int i = 0; i < v.exp_words; i++) begin
            ea = v.addr + 28'(i * STEP);
            if (i >= cmd_addr_log.size()) bad++;
            else if (cmd_addr_log[i] !== ea || cmd_code_log[i] !== (v.wr ? 3'b000 : 3'b001)) bad++;
            if (v.wr) begin
                if (i >= wdata_log.size() || wdata_log[i] !== src_mem[i]) bad++;
            end else begin
                if (i >= we_addr_log.size() || we_addr_log[i] !== MD'(i) || dst_mem[i] !== rd_val(ea)) bad++;
            end
        end
        check({nm, " bad items"}, bad, 0);
        check({nm, " last addr"}, (cmd_addr_log.size() > 0) ? cmd_addr_log[$] : 28'hXXXXXXX, v.exp_last);
        check({nm, " idle/err/end"}, {o_busy, o_error, (end_bad != 0)}, 3'b000);
    endtask

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [27:0] ea;
        for (int i = 0; i < (1 << MD); i++) src_mem[i] = 32'hA000_0000 + i;
        //            wr    addr          count   lat stall words en   last
        vecs[0] = '{1'b1, 28'h0000100, 11'd4,    0, 0,    4,    4,   28'h0000118};
        vecs[1] = '{1'b1, 28'h0000200, 11'd2,    0, 3,    2,    5,   28'h0000208};
        vecs[2] = '{1'b0, 28'h0000000, 11'd3,    5, 0,    3,    3,   28'h0000010};
        vecs[3] = '{1'b0, 28'h0000040, 11'd6,    1, 0,    6,    6,   28'h0000068};
        vecs[4] = '{1'b0, 28'h0000300, 11'd5,    2, 0,    5,    5,   28'h0000320};
        vecs[5] = '{1'b1, 28'hFFFFFF8, 11'd3,    0, 0,    3,    3,   28'h0000008};
        vecs[6] = '{1'b0, 28'h0001000, 11'h7FF,  3, 0, 1024, 1024,   28'h0002FF8};

        rst = 1'b1; i_start_wr = 1'b0; i_start_rd = 1'b0; i_ddr_addr = '0; i_count = '0;
        repeat (3) @(negedge clk);
        #2;
        check("reset ctrl outputs", {o_busy, o_done, o_error, o_bram_we, o_bram_addr, o_app_en,
              o_app_cmd, o_app_addr, o_app_wdf_wren, o_app_wdf_end}, 64'h0);
        check("reset data outputs", {o_bram_din, o_app_wdf_data}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) run_vec($sformatf("vec%0d", k), vecs[k]);

        // Zero-length transfer completes immediately without bus activity.
        clear_logs();
        start(1'b1, 1'b0, 28'h0000400, 11'd0);
        wait_done(20);
        check("zero count done latency", done_cyc - st_cyc, 1);
        check("zero count activity", {en_cycles[15:0], we_addr_log.size()}, 0);
        check("zero count done pulses", done_cnt, 1);

        // Simultaneous starts: write wins.
        clear_logs();
        start(1'b1, 1'b1, 28'h0000500, 11'd2);
        wait_done(200);
        check("priority cmds", cmd_addr_log.size(), 2);
        check("priority cmd codes", (cmd_code_log.size() == 2) ? {cmd_code_log[0], cmd_code_log[1]} : 6'h3F, 6'h0);
        check("priority bram writes", we_addr_log.size(), 0);

        // A start while busy is ignored.
        clear_logs();
        start(1'b1, 1'b0, 28'h0000600, 11'd3);
        i_start_rd = 1'b1; i_count = 11'd5;
        @(negedge clk);
        i_start_rd = 1'b0;
        wait_done(200);
        repeat (5) @(negedge clk);
        #2;
        check("busy-start done pulses", done_cnt, 1);
        check("busy-start app_en cycles", en_cycles, 3);
        check("busy-start idle", o_busy, 0);

        // Reset in the middle of the second word of a write.
        clear_logs();
        start(1'b1, 1'b0, 28'h0000100, 11'd4);
        for (int t = 0; t < 50 && cmd_addr_log.size() < 1; t++) @(negedge clk);
        check("mid-reset first cmd seen", cmd_addr_log.size(), 1);
        @(negedge clk);
        #2;
        check("mid-reset busy before", o_busy, 1);
        rst = 1'b1;
        #1;
        check("mid-reset ctrl outputs", {o_busy, o_done, o_error, o_bram_we, o_bram_addr, o_app_en,
              o_app_cmd, o_app_addr, o_app_wdf_wren, o_app_wdf_end}, 64'h0);
        check("mid-reset data outputs", {o_bram_din, o_app_wdf_data}, 64'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("mid-reset no done", done_cnt, 0);
        v = '{1'b1, 28'h0000700, 11'd2, 0, 0, 2, 2, 28'h0000708};
        run_vec("post-reset", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
